// File: rtl/usb_setup_decoder.sv
// SETUP transaction decoder for endpoint 0: qualifies the SETUP token, collects
// the DATA0 request (8 bytes + CRC16) and presents the standard request fields.
module usb_setup_decoder #(
  parameter logic        CHECK_CRC      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        USB_CLKIN,
  input  logic        RST,
  input  logic [6:0]  dev_addr,
  input  logic [23:0] token,
  input  logic        token_strb,
  input  logic [7:0]  pid,
  input  logic [7:0]  data,
  input  logic        data_strb,
  input  logic        data_end,
  input  logic        data_fail,
  output logic [7:0]  bmRequestType,
  output logic [7:0]  bRequest,
  output logic [15:0] wValue,
  output logic [15:0] wIndex,
  output logic [15:0] wLength,
  output logic        setup_valid,
  output logic        ack_strb,
  output logic        setup_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, RECV, CHECK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   crc_q, crc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [7:0]    shadow_q [8];
  logic [7:0]    shadow_d [8];
  logic [7:0]    req_q [8];
  logic [7:0]    req_d [8];

  logic setup_tok;
  logic unused_crc5;

  // CRC5 in token[23:19] has already been verified by the receive stage.
  assign setup_tok = (token[3:0] == 4'b1101) && (token[7:4] == ~token[3:0]) &&
                     (token[14:8] == dev_addr) && (token[18:15] == 4'd0);
  assign unused_crc5 = ^token[23:19];

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge USB_CLKIN or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      crc_q   <= 16'hFFFF;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= '0;
        req_q[i]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      tmo_q    <= tmo_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      req_q    <= req_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    tmo_d    = tmo_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    shadow_d = shadow_q;
    req_d    = req_q;
    case (state_q)
      WAIT_DATA: begin
        if (token_strb) begin
          if (setup_tok) begin
            tmo_d = '0;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (data_strb) begin
          if (pid != 8'hC3) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            shadow_d[0] = data;
            cnt_d       = 4'd1;
            crc_d       = crc16_byte(16'hFFFF, data);
            state_d     = RECV;
            if (data_end) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RECV: begin
        if (token_strb || data_fail) begin
          err_d = 1'b1;
          if (token_strb && setup_tok) begin
            state_d = WAIT_DATA;
            tmo_d   = '0;
            cnt_d   = '0;
            crc_d   = 16'hFFFF;
          end else begin
            state_d = IDLE;
          end
        end else if (data_strb && cnt_q == 4'd10) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          if (data_strb) begin
            if (cnt_q < 4'd8) shadow_d[cnt_q[2:0]] = data;
            cnt_d = cnt_q + 4'd1;
            crc_d = crc16_byte(crc_q, data);
          end
          // Verdict uses the post-byte count/CRC so the result is registered
          // on the data_end edge and shows up during the CHECK cycle.
          if (data_end) begin
            state_d = CHECK;
            if (cnt_d == 4'd10 && (!CHECK_CRC || crc_d == 16'hB001)) begin
              req_d   = shadow_d;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (token_strb && setup_tok) begin
          state_d = WAIT_DATA;
          tmo_d   = '0;
          cnt_d   = '0;
          crc_d   = 16'hFFFF;
        end
      end
    endcase
  end

  assign bmRequestType = req_q[0];
  assign bRequest      = req_q[1];
  assign wValue        = {req_q[3], req_q[2]};
  assign wIndex        = {req_q[5], req_q[4]};
  assign wLength       = {req_q[7], req_q[6]};
  assign setup_valid   = valid_q;
  assign ack_strb      = valid_q;
  assign setup_err     = err_q;

endmodule

// File: tb/tb_usb_setup_decoder.sv
// Directed bench for usb_setup_decoder: a transaction-level model predicts each
// pulse and the held request fields for a CRC-checking and a non-checking DUT.
module tb_usb_setup_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  dev_addr;
  logic [23:0] token;
  logic        token_strb;
  logic [7:0]  pid;
  logic [7:0]  data;
  logic        data_strb;
  logic        data_end;
  logic        data_fail;

  logic [7:0]  bm [2];
  logic [7:0]  br [2];
  logic [15:0] wv [2];
  logic [15:0] wi [2];
  logic [15:0] wl [2];
  logic        sv [2];
  logic        ak [2];
  logic        se [2];

  always #5 clk = ~clk;

  usb_setup_decoder #(.CHECK_CRC(1'b1), .TIMEOUT_CYCLES(1024)) dut0 (
    .USB_CLKIN(clk), .RST(rst), .dev_addr(dev_addr), .token(token), .token_strb(token_strb),
    .pid(pid), .data(data), .data_strb(data_strb), .data_end(data_end), .data_fail(data_fail),
    .bmRequestType(bm[0]), .bRequest(br[0]), .wValue(wv[0]), .wIndex(wi[0]), .wLength(wl[0]),
    .setup_valid(sv[0]), .ack_strb(ak[0]), .setup_err(se[0])
  );

  usb_setup_decoder #(.CHECK_CRC(1'b0), .TIMEOUT_CYCLES(1024)) dut1 (
    .USB_CLKIN(clk), .RST(rst), .dev_addr(dev_addr), .token(token), .token_strb(token_strb),
    .pid(pid), .data(data), .data_strb(data_strb), .data_end(data_end), .data_fail(data_fail),
    .bmRequestType(bm[1]), .bRequest(br[1]), .wValue(wv[1]), .wIndex(wi[1]), .wLength(wl[1]),
    .setup_valid(sv[1]), .ack_strb(ak[1]), .setup_err(se[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int txn = 0;

  // Transaction-level model state.
  logic [7:0]  pkt [16];
  logic        armed = 1'b0;
  logic        seen = 1'b0;
  int          tok_cyc = 0;
  int          exp_valid_at [2] = '{-1, -1};
  int          exp_err_at [2] = '{-1, -1};
  logic [55:0] mf [2] = '{56'd0, 56'd0};
  int          nvalid [2] = '{0, 0};
  int          nerr [2] = '{0, 0};
  logic        run_cmp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [55:0] fields(input int d);
    return {bm[d], br[d], wv[d], wi[d], wl[d]};
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sv[d]) nvalid[d]++;
      if (se[d]) nerr[d]++;
      if (!rst && run_cmp) begin
        chk($sformatf("valid%0d", d), 64'(sv[d]), 64'(cyc == exp_valid_at[d]));
        chk($sformatf("ack%0d", d),   64'(ak[d]), 64'(cyc == exp_valid_at[d]));
        chk($sformatf("err%0d", d),   64'(se[d]), 64'(cyc == exp_err_at[d]));
        chk($sformatf("fields%0d", d), 64'(fields(d)), 64'(mf[d]));
      end
    end
  end

  function automatic logic [15:0] crc16(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pkt[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    return c;
  endfunction

  task automatic make_pkt(input logic [63:0] req);
    logic [15:0] c;
    for (int i = 0; i < 8; i++) pkt[i] = req[63-8*i -: 8];
    c = crc16(8);
    pkt[8] = ~c[7:0];
    pkt[9] = ~c[15:8];
    for (int i = 10; i < 16; i++) pkt[i] = 8'(8'hA0 + i);
  endtask

  task automatic drive(input logic ts, input logic [23:0] tk, input logic ds,
                       input logic [7:0] dd, input logic de, input logic df);
    token_strb = ts; token = tk; data_strb = ds; data = dd; data_end = de; data_fail = df;
    @(posedge clk); #1;
    token_strb = 1'b0; data_strb = 1'b0; data_end = 1'b0; data_fail = 1'b0;
  endtask

  task automatic expect_err();
    exp_err_at[0] = cyc;
    exp_err_at[1] = cyc;
    armed = 1'b0;
  endtask

  task automatic finish_pkt(input int k);
    for (int d = 0; d < 2; d++) begin
      if (k == 10 && (d == 1 || crc16(10) == 16'hB001)) begin
        exp_valid_at[d] = cyc;
        mf[d] = {pkt[0], pkt[1], pkt[3], pkt[2], pkt[5], pkt[4], pkt[7], pkt[6]};
      end else begin
        exp_err_at[d] = cyc;
      end
    end
    armed = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      drive(1'b0, 24'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      if (armed && !seen && (cyc - tok_cyc) == 1024) expect_err();
    end
  endtask

  task automatic send_token(input logic [23:0] tk);
    logic q;
    q = (tk[7:0] == 8'h2D) && (tk[14:8] == dev_addr) && (tk[18:15] == 4'd0);
    drive(1'b1, tk, 1'b0, 8'd0, 1'b0, 1'b0);
    if (armed && (seen || !q)) expect_err();
    armed   = q;
    seen    = 1'b0;
    tok_cyc = cyc;
  endtask

  // end_mode: 0 = no data_end, 1 = data_end after last byte, 2 = with last byte
  task automatic send_payload(input int n, input int end_mode);
    logic de;
    for (int i = 0; i < n; i++) begin
      de = (end_mode == 2) && (i == n - 1);
      drive(1'b0, 24'd0, 1'b1, pkt[i], de, 1'b0);
      if (armed) begin
        seen = 1'b1;
        if (i == 0 && pid != 8'hC3) expect_err();
        else if (i >= 10)           expect_err();
        else if (de)                finish_pkt(i + 1);
      end
    end
    if (end_mode == 1) begin
      drive(1'b0, 24'd0, 1'b0, 8'd0, 1'b1, 1'b0);
      if (armed) finish_pkt(n);
    end
  endtask

  task automatic send_fail();
    drive(1'b0, 24'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    if (armed && seen) expect_err();
  endtask

  task automatic note(input string s);
    txn++;
    $display("txn %0d @cycle %0d: %s", txn, cyc, s);
  endtask

  initial begin
    rst = 1'b1; dev_addr = 7'd0; token = 24'd0; token_strb = 1'b0; pid = 8'hC3;
    data = 8'd0; data_strb = 1'b0; data_end = 1'b0; data_fail = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", 64'(sv[d]), 64'd0);
      chk("reset_ack", 64'(ak[d]), 64'd0);
      chk("reset_err", 64'(se[d]), 64'd0);
      chk("reset_fields", 64'(fields(d)), 64'd0);
    end
    rst = 1'b0;
    run_cmp = 1'b1;
    idle(2);

    note("good GET_DESCRIPTOR request");
    make_pkt(64'h8006_0001_0000_4000);
    send_token(24'h10002D);
    send_payload(10, 1);
    idle(3);
    chk("good_bm", 64'(bm[0]), 64'h80);
    chk("good_breq", 64'(br[0]), 64'h06);
    chk("good_wvalue", 64'(wv[0]), 64'h0100);
    chk("good_windex", 64'(wi[0]), 64'h0000);
    chk("good_wlength", 64'(wl[0]), 64'h0040);
    chk("good_single_pulse", 64'(nvalid[0]), 64'd1);

    note("corrupt CRC SET_CONFIGURATION");
    make_pkt(64'h0009_0100_0000_0000);
    pkt[9] = pkt[9] ^ 8'h01;
    send_token(24'h10002D);
    send_payload(10, 1);
    idle(3);
    chk("crc_bad_keeps_breq", 64'(br[0]), 64'h06);
    chk("crc_bad_err_count", 64'(nerr[0]), 64'd1);
    chk("nocrc_breq", 64'(br[1]), 64'h09);
    chk("nocrc_wvalue", 64'(wv[1]), 64'h0001);

    note("wrong address");
    dev_addr = 7'h05;
    make_pkt(64'h8006_0001_0000_4000);
    send_token(24'h10002D);
    send_payload(10, 1);
    idle(3);
    dev_addr = 7'h00;

    note("OUT token ignored");
    send_token(24'h1000E1);
    send_payload(10, 1);
    idle(3);

    note("DATA1 after SETUP");
    pid = 8'h4B;
    send_token(24'h10002D);
    send_payload(10, 1);
    idle(3);
    pid = 8'hC3;

    note("9 bytes then data_end");
    send_token(24'h10002D);
    send_payload(9, 1);
    idle(3);

    note("11 data strobes");
    send_token(24'h10002D);
    send_payload(11, 1);
    idle(3);

    note("data_fail after byte 4, then orphan packet");
    send_token(24'h10002D);
    send_payload(4, 0);
    send_fail();
    idle(2);
    send_payload(10, 1);
    idle(3);

    note("second SETUP during RECV, then GET_STATUS");
    send_token(24'h10002D);
    send_payload(3, 0);
    send_token(24'h10002D);
    make_pkt(64'h8000_0000_0000_0200);
    send_payload(10, 1);
    idle(3);
    chk("preempt_wlength", 64'(wl[0]), 64'h0002);
    chk("preempt_bm", 64'(bm[0]), 64'h80);

    note("data_end together with last byte");
    make_pkt(64'h0005_2A00_0000_0000);
    send_token(24'h10002D);
    send_payload(10, 2);
    idle(3);
    chk("merged_wvalue", 64'(wv[0]), 64'h002A);

    note("timeout with no data");
    send_token(24'h10002D);
    idle(1030);
    chk("timeout_err_cycle", 64'(exp_err_at[0] - tok_cyc), 64'd1024);

    note("async reset mid-RECV");
    make_pkt(64'h8006_0002_0000_FF00);
    send_token(24'h10002D);
    send_payload(4, 0);
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_rst_valid", 64'(sv[d]), 64'd0);
      chk("async_rst_err", 64'(se[d]), 64'd0);
      chk("async_rst_fields", 64'(fields(d)), 64'd0);
    end
    armed = 1'b0; seen = 1'b0; mf[0] = '0; mf[1] = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    note("good packet after reset");
    send_token(24'h10002D);
    send_payload(10, 1);
    idle(3);
    chk("post_rst_wvalue", 64'(wv[0]), 64'h0200);
    chk("post_rst_wlength", 64'(wl[0]), 64'h00FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
